// File: rtl/sim_end_pkg.sv
// Shared encodings for the end-of-simulation controller: end causes and FSM states.
package sim_end_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_DONE    = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_ERROR   = 2'd3
  } end_cause_e;

  typedef enum logic [2:0] {
    WAIT_HOST = 3'd0,
    RUN       = 3'd1,
    QUIET     = 3'd2,
    DRAIN     = 3'd3,
    ENDED     = 3'd4
  } state_e;

endpackage

// File: rtl/sim_end_ctrl_if.sv
// Bundle between the bench environment (master) and the end-of-simulation controller (slave).
interface sim_end_ctrl_if #(
  parameter int NUM_SRC = 5,
  parameter int CNT_W   = 32
);

  logic                    host_active;
  logic [NUM_SRC-1:0]      src_done;
  logic [NUM_SRC-1:0]      src_err;
  logic                    cfg_use_done;
  logic [CNT_W-1:0]        cfg_timeout;
  logic                    sim_end;
  logic                    finish_req;
  sim_end_pkg::end_cause_e end_cause;
  logic [NUM_SRC-1:0]      err_src;
  logic [CNT_W-1:0]        cycles;

  modport master (
    output host_active, src_done, src_err, cfg_use_done, cfg_timeout,
    input  sim_end, finish_req, end_cause, err_src, cycles
  );

  modport slave (
    input  host_active, src_done, src_err, cfg_use_done, cfg_timeout,
    output sim_end, finish_req, end_cause, err_src, cycles
  );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: clear wins, otherwise counts on inc unless frozen, sticks at all-ones.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         inc,
  input  logic         freeze,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (inc && !freeze && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/sim_end_ctrl.sv
// End-of-simulation controller: watches done/error sources and a cycle timeout, then
// raises sim_end, drains for DRAIN_CYCLES and pulses finish_req once.
module sim_end_ctrl
  import sim_end_pkg::*;
#(
  parameter int NUM_SRC         = 5,
  parameter int CNT_W           = 32,
  parameter int DEFAULT_TIMEOUT = 10_000_000,
  parameter int QUIET_CYCLES    = 16,
  parameter int DRAIN_CYCLES    = 100
) (
  input logic          clk,
  input logic          reset,
  sim_end_ctrl_if.slave bus
);

  localparam int QW = $clog2(QUIET_CYCLES + 1);
  localparam int DW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [QW-1:0]    QUIET_LAST   = QW'(QUIET_CYCLES);
  localparam logic [DW-1:0]    DRAIN_LAST   = DW'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_DFLT = CNT_W'(DEFAULT_TIMEOUT);

  state_e             state;
  logic               sim_end_q;
  logic               finish_q;
  end_cause_e         cause_q;
  logic [NUM_SRC-1:0] err_q;
  logic [CNT_W-1:0]   timeout_q;
  logic               timeout_vld;
  logic [CNT_W-1:0]   cycles_q;
  logic [CNT_W-1:0]   cycles_nxt;
  logic [CNT_W-1:0]   timeout_eff;
  logic [QW-1:0]      quiet_q;
  logic [DW-1:0]      drain_q;
  logic               live;
  logic               all_done;
  logic               quiet_ok;
  logic               err_hit;
  logic               timeout_hit;
  logic               done_hit;

  assign live     = (state == WAIT_HOST) || (state == RUN) || (state == QUIET);
  // Case equality so an X/Z done flag never counts as done.
  assign all_done = (bus.src_done === {NUM_SRC{1'b1}});
  assign quiet_ok = bus.cfg_use_done && all_done && ((state == RUN) || (state == QUIET));
  assign err_hit  = |bus.src_err;

  // Timeout is matched against the value cycles takes on this edge, so the decision
  // lands on the same edge the count reaches it. The first edge uses the live config.
  assign cycles_nxt  = (&cycles_q) ? cycles_q : cycles_q + CNT_W'(1);
  assign timeout_eff = timeout_vld ? timeout_q
                     : ((bus.cfg_timeout == '0) ? TIMEOUT_DFLT : bus.cfg_timeout);
  assign timeout_hit = (cycles_nxt == timeout_eff);
  assign done_hit    = (state == QUIET) && quiet_ok && (quiet_q == QUIET_LAST);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk    (clk),
    .clear  (reset),
    .inc    (1'b1),
    .freeze (!live),
    .count  (cycles_q)
  );

  // Cleared whenever the all-done streak is broken, so it reads 1 on entry to QUIET.
  sat_counter #(.W(QW)) u_quiet_cnt (
    .clk    (clk),
    .clear  (reset || !quiet_ok),
    .inc    (quiet_ok),
    .freeze (1'b0),
    .count  (quiet_q)
  );

  sat_counter #(.W(DW)) u_drain_cnt (
    .clk    (clk),
    .clear  (reset || (state != DRAIN)),
    .inc    (1'b1),
    .freeze (1'b0),
    .count  (drain_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT_HOST;
      sim_end_q   <= 1'b0;
      finish_q    <= 1'b0;
      cause_q     <= CAUSE_NONE;
      err_q       <= '0;
      timeout_q   <= '0;
      timeout_vld <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (!timeout_vld) begin
        timeout_q   <= timeout_eff;
        timeout_vld <= 1'b1;
      end
      if (live && (err_hit || timeout_hit || done_hit)) begin
        state     <= DRAIN;
        sim_end_q <= 1'b1;
        err_q     <= bus.src_err;
        cause_q   <= err_hit ? CAUSE_ERROR : (timeout_hit ? CAUSE_TIMEOUT : CAUSE_DONE);
      end else begin
        unique case (state)
          WAIT_HOST: if (bus.host_active) state <= RUN;
          RUN:       if (quiet_ok) state <= QUIET;
          QUIET:     if (!quiet_ok) state <= RUN;
          DRAIN: begin
            if (drain_q == DRAIN_LAST) begin
              finish_q <= 1'b1;
              state    <= ENDED;
            end
          end
          ENDED:     state <= ENDED;
          default:   state <= WAIT_HOST;
        endcase
      end
    end
  end

  assign bus.sim_end    = sim_end_q;
  assign bus.finish_req = finish_q;
  assign bus.end_cause  = cause_q;
  assign bus.err_src    = err_q;
  assign bus.cycles     = cycles_q;

endmodule
